// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph constants, field widths, limits and FSM state type
// for the seven-segment time reader. Imported by seg7_digit_decode and
// seg7_time_reader. Optional macro SEG7_ALT_GLYPH_EN enables the ALT glyphs.
package seg7_pkg;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    // Alternate renderings some display drivers use
    localparam logic [6:0] SEG_6_ALT = 7'h7C;
    localparam logic [6:0] SEG_7_ALT = 7'h27;
    localparam logic [6:0] SEG_9_ALT = 7'h67;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    localparam logic [6:0] MAX_HOUR = 7'd23;
    localparam logic [6:0] MAX_MIN  = 7'd59;

    typedef enum logic {
        ST_WAIT,
        ST_OFFER
    } state_e;

    // d*10 as (d<<3)+(d<<1); result fits 7 bits for d<=9
    function automatic logic [6:0] times10(input logic [3:0] d);
        logic [6:0] w;
        w = {3'b000, d};
        return (w << 3) + (w << 1);
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// seg7_digit_decode: combinational active-high 7-seg glyph to BCD digit.
// Ports: seg_i[6:0] {g..a}, valid_o (recognised glyph), digit_o[3:0].
// Macro SEG7_ALT_GLYPH_EN additionally accepts the alternate 6/7/9 glyphs.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic [3:0] digit_o
);

    always_comb begin
        valid_o = 1'b1;
        digit_o = 4'd0;
        case (seg_i)
            SEG_0: digit_o = 4'd0;
            SEG_1: digit_o = 4'd1;
            SEG_2: digit_o = 4'd2;
            SEG_3: digit_o = 4'd3;
            SEG_4: digit_o = 4'd4;
            SEG_5: digit_o = 4'd5;
            SEG_6: digit_o = 4'd6;
            SEG_7: digit_o = 4'd7;
            SEG_8: digit_o = 4'd8;
            SEG_9: digit_o = 4'd9;
`ifdef SEG7_ALT_GLYPH_EN
            SEG_6_ALT: digit_o = 4'd6;
            SEG_7_ALT: digit_o = 4'd7;
            SEG_9_ALT: digit_o = 4'd9;
`endif
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_time_reader.sv
// seg7_time_reader: decodes six 7-seg digit buses into hh:mm:ss, waits for a
// stable snapshot, range-checks it and offers each new time on valid/ready.
// Ports: clk, reset (sync, active-high), disp0..disp5[6:0] (ss ones .. hh tens),
// out_ready in; out_valid, hours[4:0], minutes[5:0], seconds[5:0], err out.
// Macro SEG7_ALT_GLYPH_EN (in seg7_digit_decode) enables alternate glyphs.
module seg7_time_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        disp0,
    input  logic [6:0]        disp1,
    input  logic [6:0]        disp2,
    input  logic [6:0]        disp3,
    input  logic [6:0]        disp4,
    input  logic [6:0]        disp5,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [MIN_W-1:0]  seconds,
    output logic              err
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [41:0]      raw;
    logic [41:0]      norm;
    logic [41:0]      snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mismatch;
    logic             settled;

    assign raw      = {disp5, disp4, disp3, disp2, disp1, disp0};
    assign norm     = ACTIVE_LOW ? ~raw : raw;
    assign mismatch = (norm != snap_q);
    assign settled  = (cnt_q == CNT_MAX);

    always_comb begin
        snap_d = snap_q;
        cnt_d  = cnt_q;
        if (mismatch) begin
            snap_d = norm;
            cnt_d  = '0;
        end else if (!settled) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q <= '0;
            cnt_q  <= '0;
        end else begin
            snap_q <= snap_d;
            cnt_q  <= cnt_d;
        end
    end

    // Decode the registered snapshot, never the live buses
    logic [5:0] dvld;
    logic [3:0] dig [6];

    for (genvar i = 0; i < 6; i++) begin : g_dec
        seg7_digit_decode u_dec (
            .seg_i   (snap_q[i*7 +: 7]),
            .valid_o (dvld[i]),
            .digit_o (dig[i])
        );
    end

    logic [6:0] hr_bin, min_bin, sec_bin;
    logic       time_ok;

    assign hr_bin  = times10(dig[5]) + {3'b000, dig[4]};
    assign min_bin = times10(dig[3]) + {3'b000, dig[2]};
    assign sec_bin = times10(dig[1]) + {3'b000, dig[0]};
    assign time_ok = (&dvld) && (hr_bin <= MAX_HOUR)
                  && (min_bin <= MAX_MIN) && (sec_bin <= MAX_MIN);

    state_e           state_q;
    logic             out_valid_q;
    logic [HOUR_W-1:0] hours_q;
    logic [MIN_W-1:0] minutes_q;
    logic [MIN_W-1:0] seconds_q;
    logic             err_q;
    logic             err_flag_q;
    logic             rep_vld_q;
    logic [41:0]      last_q;
    logic             is_new;
    logic             err_fire;

    assign is_new   = !rep_vld_q || (snap_q != last_q);
    // err fires once per settled invalid snapshot; the flag re-arms on change
    assign err_fire = (state_q == ST_WAIT) && settled && !time_ok && !err_flag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WAIT;
            out_valid_q <= 1'b0;
            hours_q     <= '0;
            minutes_q   <= '0;
            seconds_q   <= '0;
            err_q       <= 1'b0;
            err_flag_q  <= 1'b0;
            rep_vld_q   <= 1'b0;
            last_q      <= '0;
        end else begin
            err_q      <= err_fire;
            err_flag_q <= mismatch ? 1'b0 : (err_flag_q | err_fire);
            unique case (state_q)
                ST_WAIT: begin
                    if (settled && time_ok && is_new) begin
                        hours_q     <= hr_bin[HOUR_W-1:0];
                        minutes_q   <= min_bin[MIN_W-1:0];
                        seconds_q   <= sec_bin[MIN_W-1:0];
                        last_q      <= snap_q;
                        rep_vld_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                default: state_q <= ST_WAIT;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign hours     = hours_q;
    assign minutes   = minutes_q;
    assign seconds   = seconds_q;
    assign err       = err_q;

endmodule
